fp_addsub_seq: RTL and testbench

Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor. It is the next generation of the team's serial FP adder. Both operands load in parallel behind a valid/ready handshake, and an add/sub mode bit is registered with them. Alignment and normalisation are iterative (one bit per cycle). IEEE special values, status flags and output backpressure are handled. It sits between an operand scheduler and a result consumer in the datapath.

---
 rtl/fp_addsub_seq_if.sv | 35 +++
 rtl/fp_addsub_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_seq_if.sv
// fp_addsub_seq_if
// Operand/result handshake bundle for the sequential FP adder/subtractor.
//   in_valid/in_ready  : operand handshake, op_a/op_b/sub qualified by in_valid
//   op_a, op_b         : packed operands {sign, exp, frac}
//   sub                : 0 = A+B, 1 = A-B
//   out_valid/out_ready: result handshake, result/flags qualified by out_valid
//   result             : packed result
//   flags              : {invalid, overflow, underflow, inexact}
// Modports: master = operand scheduler / result consumer side, slave = adder.
interface fp_addsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq
// Multi-cycle floating-point adder/subtractor. Operands are captured in
// parallel, alignment and normalisation shift one bit per cycle.
// Ports:
//   clock  : rising-edge clock
//   nreset : synchronous active-low reset
//   bus    : fp_addsub_seq_if.slave (operand and result handshakes)
// Build option: define FPADD_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise results are truncated and overflow saturates to max finite.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic            clock,
  input logic            nreset,
  fp_addsub_seq_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  // Working mantissa: {carry, hidden, frac, guard, round, sticky}
  localparam int MW = MAN_W + 5;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W:0]   EXP_TOP  = {1'b0, EXP_ONES};
  localparam logic [EXP_W:0]   E_ONE    = (EXP_W+1)'(1);
  localparam logic [EXP_W-1:0] DIFF_MAX = EXP_W'(MAN_W + 3);
  localparam logic [EXP_W-1:0] DIFF_ONE = EXP_W'(1);

  typedef enum logic [2:0] {IDLE, CHECK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state;

  logic [W-1:0]   a_q, b_q;
  logic           sx, sy, special;
  logic [EXP_W:0] ex;
  logic [EXP_W-1:0] diff;
  logic [MW-1:0]  mx, my;
  logic [W-1:0]   result_q;
  logic [3:0]     flags_q;
  logic           out_valid_q;

  // Operand unpack, special-value screening and the swap that puts the
  // larger exponent in X. b_q already carries the effective sign of B.
  logic             a_s, b_s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [EXP_W-1:0] a_e, b_e, chk_diff;
  logic [MAN_W-1:0] a_f, b_f;
  logic [W-1:0]     chk_res;
  logic [3:0]       chk_flags;
  logic             chk_special, chk_sx, chk_sy;
  logic [EXP_W:0]   chk_ex;
  logic [MW-1:0]    chk_mx, chk_my;

  always_comb begin
    {a_s, a_e, a_f} = a_q;
    {b_s, b_e, b_f} = b_q;
    a_nan  = (a_e == EXP_ONES) && (a_f != '0);
    b_nan  = (b_e == EXP_ONES) && (b_f != '0);
    a_inf  = (a_e == EXP_ONES) && (a_f == '0);
    b_inf  = (b_e == EXP_ONES) && (b_f == '0);
    a_zero = (a_e == '0);
    b_zero = (b_e == '0);
    chk_special = 1'b1;
    chk_flags   = 4'b0000;
    chk_res     = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
      chk_res   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      chk_flags = 4'b1000;
    end else if (a_inf) begin
      chk_res = a_q;
    end else if (b_inf) begin
      chk_res = b_q;
    end else if (a_zero && b_zero) begin
      chk_res = {a_s & b_s, {(W-1){1'b0}}};
    end else if (a_zero) begin
      chk_res = b_q;
    end else if (b_zero) begin
      chk_res = a_q;
    end else begin
      chk_special = 1'b0;
    end
    if (b_e > a_e) begin
      chk_sx   = b_s;
      chk_sy   = a_s;
      chk_ex   = {1'b0, b_e};
      chk_diff = b_e - a_e;
      chk_mx   = {2'b01, b_f, 3'b000};
      chk_my   = {2'b01, a_f, 3'b000};
    end else begin
      chk_sx   = a_s;
      chk_sy   = b_s;
      chk_ex   = {1'b0, a_e};
      chk_diff = a_e - b_e;
      chk_mx   = {2'b01, a_f, 3'b000};
      chk_my   = {2'b01, b_f, 3'b000};
    end
  end

  // Rounding of the normalised mantissa in mx, plus the overflow decision.
  logic             grs, rnd_inc;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] rnd_f;
  logic [EXP_W:0]   rnd_e;
  logic [W-1:0]     rnd_res;
  logic [3:0]       rnd_flags;

  always_comb begin
    grs = |mx[2:0];
`ifdef FPADD_ROUND_NEAREST_EN
    rnd_inc = mx[2] & (mx[1] | mx[0] | mx[3]);
`else
    rnd_inc = 1'b0;
`endif
    rnd = mx[MW-1:3] + {{(MAN_W+1){1'b0}}, rnd_inc};
    // A carry out of the hidden bit leaves 10.000..0, renormalise by one
    if (rnd[MAN_W+1]) begin
      rnd_f = rnd[MAN_W:1];
      rnd_e = ex + E_ONE;
    end else begin
      rnd_f = rnd[MAN_W-1:0];
      rnd_e = ex;
    end
    if (rnd_e >= EXP_TOP) begin
`ifdef FPADD_ROUND_NEAREST_EN
      rnd_res = {sx, EXP_ONES, {MAN_W{1'b0}}};
`else
      rnd_res = {sx, EXP_ONES - DIFF_ONE, {MAN_W{1'b1}}};
`endif
      rnd_flags = 4'b0101;
    end else begin
      rnd_res   = {sx, rnd_e[EXP_W-1:0], rnd_f};
      rnd_flags = {3'b000, grs};
    end
  end

  // Control FSM and datapath registers. Special results found in CHECK pass
  // through ROUND untouched so they surface two edges after the accept.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      special     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.op_a;
            b_q   <= {bus.op_b[W-1] ^ bus.sub, bus.op_b[W-2:0]};
            state <= CHECK;
          end
        end
        CHECK: begin
          special  <= chk_special;
          result_q <= chk_res;
          flags_q  <= chk_flags;
          sx       <= chk_sx;
          sy       <= chk_sy;
          ex       <= chk_ex;
          diff     <= chk_diff;
          mx       <= chk_mx;
          my       <= chk_my;
          if (chk_special)
            state <= ROUND;
          else if (chk_diff != '0)
            state <= ALIGN;
          else
            state <= ADD;
        end
        ALIGN: begin
          // Beyond MAN_W+3 every bit of mY lands in sticky, so do it at once
          if (diff > DIFF_MAX) begin
            my    <= {{(MW-1){1'b0}}, |my};
            state <= ADD;
          end else begin
            my   <= {1'b0, my[MW-1:2], my[1] | my[0]};
            diff <= diff - DIFF_ONE;
            if (diff == DIFF_ONE)
              state <= ADD;
          end
        end
        ADD: begin
          if (sx == sy) begin
            mx    <= mx + my;
            state <= NORM;
          end else if (mx == my) begin
            result_q    <= '0;
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (mx > my) begin
            mx    <= mx - my;
            state <= NORM;
          end else begin
            mx    <= my - mx;
            sx    <= sy;
            state <= NORM;
          end
        end
        NORM: begin
          if (mx[MW-1]) begin
            mx    <= {1'b0, mx[MW-1:2], mx[1] | mx[0]};
            ex    <= ex + E_ONE;
            state <= ROUND;
          end else if (mx[MW-2]) begin
            state <= ROUND;
          end else if (ex == E_ONE) begin
            result_q    <= {sx, {(W-1){1'b0}}};
            flags_q     <= 4'b0011;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            mx <= {mx[MW-2:0], 1'b0};
            ex <= ex - E_ONE;
          end
        end
        ROUND: begin
          if (!special) begin
            result_q <= rnd_res;
            flags_q  <= rnd_flags;
          end
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is forced low while reset is asserted, even before the first edge
  assign bus.in_ready  = nreset && (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq
// Scoreboard bench for fp_addsub_seq (single precision). Stimulus pushes the
// hand-computed expected result, flags and latency; a monitor pops and
// compares whenever the adder hands over a result.
module tb_fp_addsub_seq;
  localparam int W = 32;

  logic clock = 1'b0;
  logic nreset;

  fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

`ifdef FPADD_ROUND_NEAREST_EN
  localparam logic [31:0] EXP_LSB_UP = 32'h3F800002;
  localparam logic [31:0] EXP_CARRY  = 32'h40000000;
  localparam logic [31:0] EXP_OVF    = 32'h7F800000;
`else
  localparam logic [31:0] EXP_LSB_UP = 32'h3F800001;
  localparam logic [31:0] EXP_CARRY  = 32'h3FFFFFFF;
  localparam logic [31:0] EXP_OVF    = 32'h7F7FFFFF;
`endif

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           lat;
    int           accept;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cycle_cnt = 0;
  bit   seen      = 1'b0;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // One comparison: counts it, and reports a failure with both values
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Waits for in_ready, presents one operand pair and records the expectation
  task automatic applyStimulus(input string name, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic s,
                               input logic [W-1:0] res, input logic [3:0] flg,
                               input int lat);
    int   n = 0;
    exp_t e;
    @(negedge clock);
    while (!bus.in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) begin
      checkOutput({name, "_in_ready_timeout"}, 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    e.name   = name;
    e.res    = res;
    e.flg    = flg;
    e.lat    = lat;
    e.accept = cycle_cnt + 1;
    sb_q.push_back(e);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (sb_q.size() != 0) begin
      checkOutput("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      seen = 1'b0;
    end
  endtask

  // Monitor: latency on first sight of out_valid, data at the handshake
  initial begin
    forever begin
      @(negedge clock);
      if (nreset && bus.out_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            if (sb_q[0].lat >= 0)
              checkOutput({sb_q[0].name, "_latency"}, 32'(cycle_cnt - sb_q[0].accept),
                          32'(sb_q[0].lat));
          end
          if (bus.out_ready) begin
            checkOutput({sb_q[0].name, "_result"}, bus.result, sb_q[0].res);
            checkOutput({sb_q[0].name, "_flags"}, 32'(bus.flags), 32'(sb_q[0].flg));
            void'(sb_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    bit  saw;
    nreset        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_result", bus.result, 32'h0);
    checkOutput("reset_flags", 32'(bus.flags), 32'd0);
    nreset = 1'b1;
    @(negedge clock);
    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors: name, a, b, sub, result, flags, latency
    applyStimulus("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 4);
    applyStimulus("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, -1);
    applyStimulus("norm_left",      32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 4'b0000, 5);
    applyStimulus("two_plus_one",   32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 5);
    applyStimulus("neg_result",     32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 6);
    applyStimulus("guard_tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 28);
    applyStimulus("guard_tie_odd",  32'h3F800001, 32'h33800000, 1'b0, EXP_LSB_UP,    4'b0001, 28);
    applyStimulus("round_carry",    32'h3FFFFFFF, 32'h33800000, 1'b0, EXP_CARRY,     4'b0001, 28);
    applyStimulus("far_sticky",     32'h4F800000, 32'h3F800000, 1'b0, 32'h4F800000, 4'b0001, 5);
    applyStimulus("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, EXP_OVF,       4'b0101, 4);
    applyStimulus("inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 2);
    applyStimulus("nan_in",         32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2);
    applyStimulus("minus_inf",      32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, 2);
    applyStimulus("zero_plus_b",    32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000, 4'b0000, 2);
    applyStimulus("a_minus_zero",   32'h40400000, 32'h00000000, 1'b1, 32'h40400000, 4'b0000, 2);
    applyStimulus("neg_zero_pair",  32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, 2);
    applyStimulus("subnormal_in",   32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 2);
    applyStimulus("underflow",      32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 3);
    waitDrain();

    // Backpressure: result must hold while the consumer stalls
    @(negedge clock);
    bus.out_ready = 1'b0;
    applyStimulus("backpressure", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 4);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (10) begin
      @(negedge clock);
      checkOutput("bp_result_hold", bus.result, 32'h40000000);
      checkOutput("bp_flags_hold", 32'(bus.flags), 32'd0);
      checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      checkOutput("bp_valid_hold", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clock);
    #1 bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    waitDrain();

    // Reset during ALIGN drops the operation without any output
    applyStimulus("reset_mid_align", 32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 4'b0000, 27);
    repeat (5) @(posedge clock);
    #1 nreset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_result", bus.result, 32'h0);
    checkOutput("midrst_flags", 32'(bus.flags), 32'd0);
    sb_q.delete();
    seen   = 1'b0;
    nreset = 1'b1;
    saw    = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (bus.out_valid) saw = 1'b1;
    end
    checkOutput("midrst_no_output", 32'(saw), 32'd0);
    applyStimulus("after_reset", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 4);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
